// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: state encoding, fetch source select and opcode classes.
// Used by both the sequencer and the fetcher.
package cpu_defs;

  localparam int unsigned CPU_BITS       = 8;
  localparam int unsigned CPU_STATE_BITS = 3;
  localparam int unsigned WAIT_CNT_BITS  = 8;

  typedef enum logic [CPU_STATE_BITS-1:0] {
    STATE_RESET   = 3'd0,
    STATE_FETCH   = 3'd1,
    STATE_DECODE  = 3'd2,
    STATE_EXECUTE = 3'd3,
    STATE_MEM_RD  = 3'd4,
    STATE_MEM_WR  = 3'd5,
    STATE_HALT    = 3'd6
  } state_t;

  localparam logic FETCH_ROM = 1'b1;
  localparam logic FETCH_RAM = 1'b0;

  localparam logic [1:0] OP_ALU   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_JUMP  = 2'b11;
  localparam logic [CPU_BITS-1:0] OP_HALT = 8'hFF;

  // States that own the shared memory bus and wait on mem_ack.
  function automatic logic is_bus_state(input state_t s);
    return (s == STATE_FETCH) || (s == STATE_MEM_RD) || (s == STATE_MEM_WR);
  endfunction

endpackage

// File: rtl/cpu_sequencer_bus_watchdog.sv
// Bus wait counter: counts un-acked cycles in a bus phase and flags expiry
// on the cycle that would reach TIMEOUT without an acknowledge.
module bus_watchdog
  import cpu_defs::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic active,
  input  logic ack,
  output logic expired
);

  logic [WAIT_CNT_BITS-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (active && !ack) begin
      count <= count + WAIT_CNT_BITS'(1);
    end
  end

  // An ack on the final wait cycle suppresses expiry.
  assign expired = active && !ack && (count == WAIT_CNT_BITS'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// CPU control unit: owns the PC and state register, sequences fetch/decode/
// memory/execute phases over the shared bus, and halts with a fault on bus timeout.
module cpu_sequencer
  import cpu_defs::*;
#(
  parameter  int unsigned BITS           = 8,
  parameter  int unsigned STATE_BITS     = 3,
  parameter  int unsigned MEM_TIMEOUT    = 15,
  localparam int unsigned BITS_IDX       = BITS - 1,
  localparam int unsigned STATE_BITS_IDX = STATE_BITS - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BITS_IDX:0]     instr,
  input  logic                  acc_zero,
  input  logic                  mem_ack,
  output logic [STATE_BITS_IDX:0] state,
  output logic                  fetch_source,
  output logic [BITS_IDX:0]     pc,
  output logic [BITS_IDX:0]     ram_addr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  alu_en,
  output logic                  halted,
  output logic                  fault
);

  state_t            state_q, state_d;
  logic [BITS_IDX:0] pc_d, ram_addr_d, target;
  logic              fault_d;
  logic              wd_clear, wd_active, wd_expired;

  assign state  = STATE_BITS'(state_q);
  assign target = BITS'(instr[4:0]);

  bus_watchdog #(.TIMEOUT(MEM_TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (wd_clear),
    .active (wd_active),
    .ack    (mem_ack),
    .expired(wd_expired)
  );

  // Next-state, PC, address and fault decisions.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc;
    ram_addr_d = ram_addr;
    fault_d    = fault;
    case (state_q)
      STATE_RESET:   state_d = STATE_FETCH;
      STATE_FETCH: begin
        if (mem_ack) begin
          pc_d    = pc + BITS'(1);
          state_d = STATE_DECODE;
        end else if (wd_expired) begin
          fault_d = 1'b1;
          state_d = STATE_HALT;
        end
      end
      STATE_DECODE: begin
        if (instr == BITS'(OP_HALT)) begin
          state_d = STATE_HALT;
        end else begin
          case (instr[7:6])
            OP_ALU:   state_d = STATE_EXECUTE;
            OP_LOAD: begin
              ram_addr_d = target;
              state_d    = STATE_MEM_RD;
            end
            OP_STORE: begin
              ram_addr_d = target;
              state_d    = STATE_MEM_WR;
            end
            default: begin
              if (!instr[5] || acc_zero) pc_d = target;
              state_d = STATE_FETCH;
            end
          endcase
        end
      end
      STATE_EXECUTE: state_d = STATE_FETCH;
      STATE_MEM_RD, STATE_MEM_WR: begin
        if (mem_ack) begin
          state_d = STATE_FETCH;
        end else if (wd_expired) begin
          fault_d = 1'b1;
          state_d = STATE_HALT;
        end
      end
      STATE_HALT:    state_d = STATE_HALT;
      default:       state_d = STATE_RESET;
    endcase
    wd_active = is_bus_state(state_q);
    wd_clear  = is_bus_state(state_d) && (state_d != state_q);
  end

  // State register; Moore outputs are registered from the next state so they
  // line up with state and still clear asynchronously on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= STATE_RESET;
      pc           <= '0;
      ram_addr     <= '0;
      fault        <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      fetch_source <= FETCH_ROM;
      alu_en       <= 1'b0;
      halted       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc           <= pc_d;
      ram_addr     <= ram_addr_d;
      fault        <= fault_d;
      mem_req      <= is_bus_state(state_d);
      mem_we       <= (state_d == STATE_MEM_WR);
      fetch_source <= ((state_d == STATE_MEM_RD) || (state_d == STATE_MEM_WR)) ? FETCH_RAM : FETCH_ROM;
      alu_en       <= (state_d == STATE_EXECUTE);
      halted       <= (state_d == STATE_HALT);
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a cycle-by-cycle vector table plus
// hand-written sequences for PC wrap, bus timeout and asynchronous reset.
module tb_cpu_sequencer;

  localparam int unsigned TO = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instr;
  logic       acc_zero;
  logic       mem_ack;
  logic [2:0] state;
  logic       fetch_source;
  logic [7:0] pc;
  logic [7:0] ram_addr;
  logic       mem_req, mem_we, alu_en, halted, fault;
  logic [5:0] flags;

  int checks = 0;
  int errors = 0;

  cpu_sequencer #(.BITS(8), .STATE_BITS(3), .MEM_TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .acc_zero    (acc_zero),
    .mem_ack     (mem_ack),
    .state       (state),
    .fetch_source(fetch_source),
    .pc          (pc),
    .ram_addr    (ram_addr),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .alu_en      (alu_en),
    .halted      (halted),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  // {mem_req, mem_we, fetch_source, alu_en, halted, fault}
  assign flags = {mem_req, mem_we, fetch_source, alu_en, halted, fault};

  typedef struct {
    logic [7:0] instr;
    logic       az;
    logic       ack;
    logic [2:0] st;
    logic [7:0] pc;
    logic [7:0] ra;
    logic [5:0] fl;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    instr    = 8'h00;
    acc_zero = 1'b0;
    mem_ack  = 1'b1;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_pc"}, 32'(pc), 32'h00);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'h00);
    check({tag, "_flags"}, 32'(flags), 32'b001000);
  endtask

  initial begin
    vecs[0]  = '{8'h00, 1'b0, 1'b1, 3'd1, 8'h00, 8'h00, 6'b101000};
    vecs[1]  = '{8'h00, 1'b0, 1'b1, 3'd2, 8'h01, 8'h00, 6'b001000};
    vecs[2]  = '{8'h00, 1'b0, 1'b1, 3'd3, 8'h01, 8'h00, 6'b001100};
    vecs[3]  = '{8'h00, 1'b0, 1'b1, 3'd1, 8'h01, 8'h00, 6'b101000};
    vecs[4]  = '{8'h45, 1'b0, 1'b1, 3'd2, 8'h02, 8'h00, 6'b001000};
    vecs[5]  = '{8'h45, 1'b0, 1'b0, 3'd4, 8'h02, 8'h05, 6'b100000};
    vecs[6]  = '{8'h45, 1'b0, 1'b0, 3'd4, 8'h02, 8'h05, 6'b100000};
    vecs[7]  = '{8'h45, 1'b0, 1'b0, 3'd4, 8'h02, 8'h05, 6'b100000};
    vecs[8]  = '{8'h45, 1'b0, 1'b0, 3'd4, 8'h02, 8'h05, 6'b100000};
    vecs[9]  = '{8'h45, 1'b0, 1'b1, 3'd1, 8'h02, 8'h05, 6'b101000};
    vecs[10] = '{8'h8A, 1'b0, 1'b1, 3'd2, 8'h03, 8'h05, 6'b001000};
    vecs[11] = '{8'h8A, 1'b0, 1'b0, 3'd5, 8'h03, 8'h0A, 6'b110000};
    vecs[12] = '{8'h8A, 1'b0, 1'b0, 3'd5, 8'h03, 8'h0A, 6'b110000};
    vecs[13] = '{8'h8A, 1'b0, 1'b1, 3'd1, 8'h03, 8'h0A, 6'b101000};
    vecs[14] = '{8'hE3, 1'b0, 1'b1, 3'd2, 8'h04, 8'h0A, 6'b001000};
    vecs[15] = '{8'hE3, 1'b0, 1'b1, 3'd1, 8'h04, 8'h0A, 6'b101000};
    vecs[16] = '{8'hE3, 1'b1, 1'b1, 3'd2, 8'h05, 8'h0A, 6'b001000};
    vecs[17] = '{8'hE3, 1'b1, 1'b1, 3'd1, 8'h03, 8'h0A, 6'b101000};
    vecs[18] = '{8'hC7, 1'b0, 1'b1, 3'd2, 8'h04, 8'h0A, 6'b001000};
    vecs[19] = '{8'hC7, 1'b0, 1'b1, 3'd1, 8'h07, 8'h0A, 6'b101000};
    vecs[20] = '{8'hFF, 1'b0, 1'b1, 3'd2, 8'h08, 8'h0A, 6'b001000};
    vecs[21] = '{8'hFF, 1'b0, 1'b1, 3'd6, 8'h08, 8'h0A, 6'b001010};
    vecs[22] = '{8'hFF, 1'b0, 1'b1, 3'd6, 8'h08, 8'h0A, 6'b001010};

    do_reset();
    check_reset_vals("reset");

    // Main instruction trace: ALU, LOAD with waits, STORE, JZ, JMP, HALT.
    for (int i = 0; i < 23; i++) begin
      instr    = vecs[i].instr;
      acc_zero = vecs[i].az;
      mem_ack  = vecs[i].ack;
      step();
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].pc));
      check($sformatf("vec%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].ra));
      check($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].fl));
    end

    // PC wrap: 255 ALU instructions bring pc to FF, the next fetch wraps to 00.
    do_reset();
    step();
    for (int n = 0; n < 255; n++) begin
      step();
      step();
      step();
    end
    check("wrap_pre_state", 32'(state), 32'd1);
    check("wrap_pre_pc", 32'(pc), 32'hFF);
    step();
    check("wrap_state", 32'(state), 32'd2);
    check("wrap_pc", 32'(pc), 32'h00);

    // Bus timeout: ack stuck low in FETCH halts after exactly TO cycles.
    do_reset();
    mem_ack = 1'b0;
    step();
    for (int n = 0; n < TO - 1; n++) step();
    check("to_pre_state", 32'(state), 32'd1);
    check("to_pre_fault", 32'(fault), 32'd0);
    step();
    check("to_state", 32'(state), 32'd6);
    check("to_fault", 32'(fault), 32'd1);
    check("to_halted", 32'(halted), 32'd1);
    check("to_pc", 32'(pc), 32'h00);
    check("to_mem_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b1;
    step();
    check("to_fault_sticky", 32'(flags), 32'b001011);

    // Ack arriving on the expiry cycle wins.
    do_reset();
    mem_ack = 1'b0;
    step();
    for (int n = 0; n < TO - 1; n++) step();
    mem_ack = 1'b1;
    step();
    check("ackwin_state", 32'(state), 32'd2);
    check("ackwin_fault", 32'(fault), 32'd0);
    check("ackwin_pc", 32'(pc), 32'h01);

    // Asynchronous reset in the middle of a store.
    do_reset();
    step();
    step();
    instr   = 8'h8A;
    mem_ack = 1'b0;
    step();
    check("wr_mem_we", 32'(mem_we), 32'd1);
    check("wr_state", 32'(state), 32'd5);
    #1 reset = 1'b0;
    #1;
    check("async_mem_we", 32'(mem_we), 32'd0);
    check_reset_vals("async");
    check("async_fault", 32'(fault), 32'd0);
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
